// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that shares one data memory between the CPU memory stage
// and a DMA/debug loader, holding strobes for MEM_LATENCY cycles per access.
module data_mem_arbiter #(
  parameter int WORD        = 64,
  parameter int MEM_LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [WORD-1:0] cpu_addr,
  input  logic [WORD-1:0] cpu_wdata,
  output logic            cpu_ack,
  output logic [WORD-1:0] cpu_rdata,
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [WORD-1:0] dma_addr,
  input  logic [WORD-1:0] dma_wdata,
  output logic            dma_ack,
  output logic [WORD-1:0] dma_rdata,
  output logic            mem_read,
  output logic            mem_write,
  output logic [WORD-1:0] mem_address,
  output logic [WORD-1:0] mem_write_data,
  input  logic [WORD-1:0] mem_read_data,
  output logic            busy
);
  localparam int CW = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            owner_q;   // 1 = DMA owns the current access
  logic            last_q;    // 1 = DMA was granted last
  logic            we_q;
  logic [WORD-1:0] addr_q, wdata_q, cpu_rdata_q, dma_rdata_q;
  logic            any_req, grant_dma;

  assign any_req   = cpu_req | dma_req;
  // On a tie the requester that was not granted last wins.
  assign grant_dma = dma_req & (~cpu_req | ~last_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read  = (state_q == ACCESS) & ~we_q;
    mem_write = (state_q == ACCESS) &  we_q;
    cpu_ack   = (state_q == DONE)   & ~owner_q;
    dma_ack   = (state_q == DONE)   &  owner_q;
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (state_q == IDLE && any_req) begin
        owner_q <= grant_dma;
        last_q  <= grant_dma;
        we_q    <= grant_dma ? dma_we    : cpu_we;
        addr_q  <= grant_dma ? dma_addr  : cpu_addr;
        wdata_q <= grant_dma ? dma_wdata : cpu_wdata;
        cnt_q   <= CW'(MEM_LATENCY - 1);
      end
      if (state_q == ACCESS) begin
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        else if (!we_q) begin
          if (owner_q) dma_rdata_q <= mem_read_data;
          else         cpu_rdata_q <= mem_read_data;
        end
      end
    end
  end

  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign cpu_rdata      = cpu_rdata_q;
  assign dma_rdata      = dma_rdata_q;

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single data memory between two requesters: the CPU memory stage and a DMA/debug loader port.
- Sequences each access over a fixed multi-cycle memory latency and returns read data with a one-cycle ack pulse.
- Arbitrates round-robin on ties.
- Sits between the Memory-stage request signals and the data_memory instance. The branch/pc_src logic stays outside this block.

Parameters:
WORD, 64, data and address width in bits (matches `WORD in constants.vh)
MEM_LATENCY, 2, cycles mem_read/mem_write are held per access; legal range 1..15

Ports:
clk  input  1  single system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
cpu_req  input  1  CPU access request; held high until cpu_ack
cpu_we  input  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  input  WORD  CPU byte address; stable while cpu_req
cpu_wdata  input  WORD  CPU write data; stable while cpu_req
cpu_ack  output  1  one-cycle completion pulse to CPU
cpu_rdata  output  WORD  registered read data for CPU
dma_req  input  1  DMA access request; held high until dma_ack
dma_we  input  1  1 = write, 0 = read
dma_addr  input  WORD  DMA byte address
dma_wdata  input  WORD  DMA write data
dma_ack  output  1  one-cycle completion pulse to DMA
dma_rdata  output  WORD  registered read data for DMA
mem_read  output  1  read strobe to data_memory
mem_write  output  1  write strobe to data_memory
mem_address  output  WORD  address to data_memory
mem_write_data  output  WORD  write data to data_memory
mem_read_data  input  WORD  read data from data_memory
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, any state, including mid-access):
  - state = IDLE; counter = 0; last_grant = DMA.
  - All outputs go to 0 on the next edge: acks, strobes, mem_address, mem_write_data, cpu_rdata, dma_rdata, busy.
  - An aborted access produces no ack. The requester re-issues after reset.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If neither req is high, stay in IDLE with strobes at 0.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester that is not last_grant. After reset the CPU therefore wins the first tie.
  - On grant:
    - Register owner, we, addr and wdata.
    - Update last_grant to the owner.
    - Load counter = MEM_LATENCY-1.
    - Go to ACCESS.
- ACCESS:
  - mem_address and mem_write_data come from the registered request.
  - mem_read = !we and mem_write = we, both held for exactly MEM_LATENCY consecutive cycles.
  - Counter decrements each cycle.
  - On the cycle with counter == 0:
    - If the access is a read, capture mem_read_data into the owner's rdata register.
    - Go to DONE.
  - A write never modifies either rdata register.
- DONE:
  - Strobes are 0.
  - The owner's ack is 1 for this single cycle.
  - Go to IDLE.
  - The requester must drop req in the cycle after the ack. The arbiter samples req again in the following IDLE cycle.
- Latency: req high in IDLE at cycle 0 → ack at cycle MEM_LATENCY+1 (cycle 3 with default).
- Throughput: one access per MEM_LATENCY+2 cycles per continuous stream.
- Fairness: with both requesters continuously requesting, grants strictly alternate. Neither requester waits more than one other access.
- Request inputs are ignored outside IDLE. Changing addr/data or dropping req mid-access is a protocol violation: the latched transaction completes and still acks.
- rdata holds its value until the next completed read by the same owner.
- Addresses pass through unmodified; there are no alignment checks.
- cpu_ack and dma_ack are never high in the same cycle. mem_read and mem_write are never high in the same cycle.

Test Plan:
- Reset, then single CPU read at addr 0x10 with memory returning 0xDEADBEEF → mem_read high cycles 1–2, cpu_ack pulse at cycle 3, cpu_rdata = 0xDEADBEEF, dma_ack stays 0.
- DMA write of 0x1234 to 0x40 → mem_write high for 2 cycles with address 0x40 and data 0x1234, dma_ack at cycle 3, dma_rdata unchanged.
- Both req high from reset, held continuously for 4 accesses → grant order CPU, DMA, CPU, DMA; acks spaced 4 cycles apart; never simultaneous.
- Reset asserted during the second ACCESS cycle of a CPU read → strobes 0 next cycle, no cpu_ack, busy 0; a following CPU read completes normally.
- MEM_LATENCY=1 build and MEM_LATENCY=4 build, single read each → ack at cycle 2 and cycle 5 respectively; strobe width 1 and 4 cycles.
- CPU read then CPU write then CPU read of the same address → second read returns the written value; cpu_rdata unchanged between the first read and the write.
